bus_port_fifo: RTL

Per-device transmit queue that feeds the shared-bus generator/arbiter. One instance per driver. The host side pushes packets in. The bus side sees a pending flag plus the head packet, and pops when granted. First-word-fall-through, with occupancy count and sticky error flags for the verification environment.

---
 rtl/bus_port_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/bus_port_fifo.sv
// Per-device transmit queue that feeds the shared-bus arbiter.
// First-word-fall-through, with an occupancy count and sticky error flags.
module bus_port_fifo #(
    parameter  int pckg_size = 8,
    parameter  int depth     = 16,
    localparam int cnt_w     = $clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [pckg_size-1:0] D_push,
    output logic                 full,
    output logic                 pndng,
    output logic [pckg_size-1:0] D_pop,
    input  logic                 pop,
    output logic [cnt_w-1:0]     count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);
    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w-1:0] last_idx = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] depth_c  = cnt_w'(depth);

    logic [pckg_size-1:0] mem [depth];
    logic [ptr_w-1:0]     wr_ptr, rd_ptr;
    logic                 empty_q, full_q;
    logic                 pop_acc, push_acc, pop_err, push_err;

    assign empty_q = (count == '0);
    assign full_q  = (count == depth_c);

    // A pop frees a slot in the same edge, so a full queue still takes a push.
    assign pop_acc  = pop && !empty_q;
    assign pop_err  = pop && empty_q;
    assign push_acc = reset && push && (!full_q || pop_acc);
    assign push_err = push && full_q && !pop_acc;

    assign pndng = !empty_q;
    assign full  = full_q;
    assign D_pop = empty_q ? '0 : mem[rd_ptr];

    // Storage has no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= D_push;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pop_acc)
                rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
            if (push_acc)
                wr_ptr <= (wr_ptr == last_idx) ? '0 : wr_ptr + 1'b1;

            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A fresh error in the clearing cycle keeps its flag set.
            if (push_err)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (pop_err)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end
endmodule
